// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared widths, video latency, CPU FSM states and byte-enable type for the VRAM arbiter
package vram_pkg;

    localparam int AW_DEF  = 12;
    localparam int DW_DEF  = 16;
    localparam int VID_LAT = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_SLOT = 2'd1,
        CPU_DATA = 2'd2,
        CPU_ACK  = 2'd3
    } state_e;

    typedef logic [1:0] be_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - requester, arbiter and RAM-side signals of the VRAM arbiter
interface vram_arbiter_if import vram_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          vid_blank;
    logic          cpu_req;
    logic          cpu_we;
    be_t           cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    be_t           ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr, vid_blank,
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  ram_rdata,
        output vid_valid, vid_data, cpu_ack, cpu_rdata,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_addr, vid_blank,
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  vid_valid, vid_data, cpu_ack, cpu_rdata
    );

    modport mem (
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/vram_sp_ram.sv
// rtl/vram_sp_ram.sv - byte-enabled single-port RAM with registered read (read-first on writes)
module vram_sp_ram import vram_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic         clock,
    vram_arbiter_if.mem ram_bus
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clock) begin
        for (int b = 0; b < DW/8; b++) begin
            if (ram_bus.ram_we[b]) begin
                mem_q[ram_bus.ram_addr][b*8 +: 8] <= ram_bus.ram_wdata[b*8 +: 8];
            end
        end
        rdata_q <= mem_q[ram_bus.ram_addr];
    end

    assign ram_bus.ram_rdata = rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter, fixed-latency scanout port over a req/ack CPU port
// Optional macro VRAM_SNOW_FREE_EN: CPU granted only while vid_blank is high.
module vram_arbiter import vram_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic           clock,
    input logic           rst,
    vram_arbiter_if.slave bus
);

    state_e               state_q, state_d;
    logic                 eligible;
    logic                 cpu_grant;
    logic                 cpu_ack;
    logic                 cpu_capture;
    logic [VID_LAT-1:0]   vid_pipe_q;
    logic                 vid_valid_q;
    logic [DW-1:0]        vid_data_q;
    logic [DW-1:0]        cpu_rdata_q;
    logic [AW-1:0]        ram_addr_q, ram_addr_d;
    be_t                  ram_we_q, ram_we_d;
    logic [DW-1:0]        ram_wdata_q, ram_wdata_d;

`ifdef VRAM_SNOW_FREE_EN
    assign eligible = bus.vid_blank;
`else
    logic unused_vid_blank;
    assign unused_vid_blank = bus.vid_blank;
    assign eligible         = 1'b1;
`endif

    // Scanout always owns the slot; the CPU only takes an otherwise idle one.
    assign cpu_grant = (state_q == IDLE) && bus.cpu_req && eligible && !bus.vid_req;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cpu_grant) state_d = CPU_SLOT;
            CPU_SLOT: state_d = CPU_DATA;
            CPU_DATA: state_d = CPU_ACK;
            CPU_ACK:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_ack     = 1'b0;
        cpu_capture = 1'b0;
        case (state_q)
            CPU_DATA: cpu_capture = 1'b1;
            CPU_ACK:  cpu_ack     = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = '0;
        ram_wdata_d = ram_wdata_q;
        if (bus.vid_req) begin
            ram_addr_d = bus.vid_addr;
        end else if (cpu_grant) begin
            ram_addr_d  = bus.cpu_addr;
            ram_we_d    = bus.cpu_we ? bus.cpu_be : '0;
            ram_wdata_d = bus.cpu_wdata;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_we_q    <= '0;
            ram_wdata_q <= '0;
            vid_pipe_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            vid_pipe_q  <= {vid_pipe_q[VID_LAT-2:0], bus.vid_req};
            vid_valid_q <= vid_pipe_q[VID_LAT-1];
            if (vid_pipe_q[VID_LAT-1]) begin
                vid_data_q <= bus.ram_rdata;
            end
            if (cpu_capture) begin
                cpu_rdata_q <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_data  = vid_data_q;
    assign bus.cpu_ack   = cpu_ack;
    assign bus.cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - scoreboard bench for vram_arbiter with vram_sp_ram alongside
module tb_vram_arbiter;
    import vram_pkg::*;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    vram_arbiter_if #(.AW(AW_DEF), .DW(DW_DEF)) bus ();

    vram_arbiter #(.AW(AW_DEF), .DW(DW_DEF)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    vram_sp_ram #(.AW(AW_DEF), .DW(DW_DEF)) ram (
        .clock   (clock),
        .ram_bus (bus)
    );

    typedef struct {
        logic [15:0] data;
        int          due;
        bit          chk;
    } exp_t;

    exp_t        vq[$];
    exp_t        cq[$];
    exp_t        ve, ce;
    logic [15:0] shadow [int];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bus.vid_valid === 1'b1) begin
            checks++;
            if (vq.size() == 0) begin
                errors++;
                $display("FAIL vid_unexpected: vid_valid=1 at cycle %0d, required no pulse", cyc);
            end else begin
                ve = vq.pop_front();
                if (bus.vid_data !== ve.data || cyc != ve.due) begin
                    errors++;
                    $display("FAIL vid_data: got %h at cycle %0d, required %h at cycle %0d",
                             bus.vid_data, cyc, ve.data, ve.due);
                end
            end
        end
        if (bus.cpu_ack === 1'b1) begin
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL cpu_ack_unexpected: cpu_ack=1 at cycle %0d, required no ack", cyc);
            end else begin
                ce = cq.pop_front();
                if (cyc != ce.due || (ce.chk && bus.cpu_rdata !== ce.data)) begin
                    errors++;
                    $display("FAIL cpu_ack: rdata %h at cycle %0d, required %h at cycle %0d",
                             bus.cpu_rdata, cyc, ce.data, ce.due);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_start(input logic we, input be_t be, input logic [11:0] addr,
                             input logic [15:0] wdata, input int due);
        exp_t        e;
        logic [15:0] old;
        e.chk = shadow.exists(int'(addr));
        old   = e.chk ? shadow[int'(addr)] : 16'h0000;
        e.data = old;
        e.due  = due;
        cq.push_back(e);
        if (we) begin
            shadow[int'(addr)] = {be[1] ? wdata[15:8] : old[15:8], be[0] ? wdata[7:0] : old[7:0]};
        end
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_be    = be;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic cpu_wait(input string name);
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            if (bus.cpu_ack === 1'b1) got = 1;
        end
        bus.cpu_req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: cpu_ack never seen, required one ack", name);
            if (cq.size() > 0) cq.delete(0);
        end
        tick();
    endtask

    task automatic cpu_access(input logic we, input be_t be, input logic [11:0] addr,
                              input logic [15:0] wdata, input string name);
        cpu_start(we, be, addr, wdata, cyc + 3);
        cpu_wait(name);
    endtask

    task automatic vid_start(input logic [11:0] addr);
        exp_t e;
        e.data = shadow[int'(addr)];
        e.due  = cyc + 3;
        e.chk  = 1;
        vq.push_back(e);
        bus.vid_req  = 1'b1;
        bus.vid_addr = addr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.vid_valid, bus.vid_data, bus.cpu_ack, bus.cpu_rdata,
             bus.ram_addr, bus.ram_we, bus.ram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: vv=%b vd=%h ack=%b rd=%h ra=%h we=%b wd=%h, required all 0",
                     bus.vid_valid, bus.vid_data, bus.cpu_ack, bus.cpu_rdata,
                     bus.ram_addr, bus.ram_we, bus.ram_wdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_video_read();
        cpu_access(1'b1, 2'b11, 12'h010, 16'h1F41, "preload");
        vid_start(12'h010);
        tick();
        bus.vid_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.cpu_ack !== 1'b0) begin
                errors++;
                $display("FAIL video_cpu_idle: cpu_ack=%b, required 0", bus.cpu_ack);
            end
        end
    endtask

    task automatic test_cpu_write_read();
        cpu_access(1'b1, 2'b11, 12'h0A5, 16'hBEEF, "write_0a5");
        cpu_access(1'b0, 2'b11, 12'h0A5, 16'h0000, "read_0a5");
    endtask

    task automatic test_byte_write();
        cpu_access(1'b1, 2'b11, 12'h020, 16'h1234, "init_020");
        cpu_access(1'b1, 2'b01, 12'h020, 16'hFFAA, "byte_020");
        cpu_access(1'b0, 2'b11, 12'h020, 16'h0000, "read_byte");
        cpu_access(1'b1, 2'b00, 12'h020, 16'h5555, "noop_write");
        cpu_access(1'b0, 2'b11, 12'h020, 16'h0000, "read_noop");
    endtask

    task automatic test_collision();
        logic [11:0] addrs [5];
        int          c0;
        addrs[0] = 12'h010; addrs[1] = 12'h0A5; addrs[2] = 12'h020;
        addrs[3] = 12'h010; addrs[4] = 12'h0A5;
        c0 = cyc;
        cpu_start(1'b0, 2'b11, 12'h020, 16'h0000, c0 + 8);
        for (int i = 0; i < 5; i++) begin
            vid_start(addrs[i]);
            tick();
        end
        bus.vid_req = 1'b0;
        cpu_wait("collision");
    endtask

    task automatic test_reset_mid();
        cpu_start(1'b0, 2'b11, 12'h0A5, 16'h0000, 0);
        cq.delete();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.vid_valid, bus.vid_data, bus.cpu_ack, bus.cpu_rdata,
             bus.ram_addr, bus.ram_we, bus.ram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: vv=%b vd=%h ack=%b rd=%h ra=%h we=%b wd=%h, required all 0",
                     bus.vid_valid, bus.vid_data, bus.cpu_ack, bus.cpu_rdata,
                     bus.ram_addr, bus.ram_we, bus.ram_wdata);
        end
        tick();
        tick();
        rst = 1'b0;
        cpu_start(1'b0, 2'b11, 12'h0A5, 16'h0000, cyc + 3);
        cpu_wait("after_reset");
        for (int i = 0; i < 5; i++) tick();
    endtask

`ifdef VRAM_SNOW_FREE_EN
    task automatic test_snow_free();
        bus.vid_blank = 1'b0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_be    = 2'b11;
        bus.cpu_addr  = 12'h010;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bus.cpu_ack !== 1'b0) begin
                errors++;
                $display("FAIL snow_no_ack: cpu_ack=%b during active display, required 0", bus.cpu_ack);
            end
        end
        bus.vid_blank = 1'b1;
        cpu_start(1'b0, 2'b11, 12'h010, 16'h0000, cyc + 3);
        cpu_wait("snow_blank");
    endtask
`endif

    initial begin
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_be    = 2'b00;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
`ifdef VRAM_SNOW_FREE_EN
        bus.vid_blank = 1'b1;
`else
        bus.vid_blank = 1'b0;
`endif
        test_reset();
        test_video_read();
        test_cpu_write_read();
        test_byte_write();
        test_collision();
        test_reset_mid();
`ifdef VRAM_SNOW_FREE_EN
        test_snow_free();
`endif
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (vq.size() != 0 || cq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d video and %0d cpu pending, required 0 and 0",
                     vq.size(), cq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
